decode_uop_sequencer: RTL and testbench
=======================================

// Module: decode_uop_sequencer
// PURPOSE
//  Consumer of the decode-table output: accepts one decoded instruction group per cycle
//  (match flag, up to two micro-op tags, count, PC) and issues micro-ops one per cycle
//  to the issue stage over a valid/ready handshake. A small FIFO decouples decode from
//  issue. Two-uop groups such as CAP_JUMP+LINK are serialised in order. Unmatched or
//  malformed groups become one flagged illegal uop.
// PARAMETERS
//  DEPTH  4   FIFO entries (uops); power of 2, >= 2
//  PC_W   24  width of instruction PC carried with each uop
// PORTS
//  clk          in   1             clock
//  rst          in   1             synchronous, active-high reset
//  flush        in   1             synchronous queue clear (pipeline redirect)
//  dec_valid    in   1             decoded group present
//  dec_ready    out  1             group accepted when dec_valid & dec_ready
//  dec_matched  in   1             decode table matched
//  dec_tag0     in   uop_tag_t     first uop tag
//  dec_tag1     in   uop_tag_t     second uop tag (used when dec_count==2)
//  dec_count    in   2             uops in group (1 or 2 valid)
//  dec_pc       in   PC_W          instruction PC
//  uop_valid    out  1             uop presented to issue
//  uop_ready    in   1             issue accepts uop
//  uop_tag      out  uop_tag_t     issued uop tag
//  uop_pc       out  PC_W          PC of parent instruction
//  uop_last     out  1             final uop of its instruction
//  uop_illegal  out  1             parent instruction did not decode
//  occupancy    out  $clog2(DEPTH)+1  uops held
// BEHAVIOUR
//  - Reset: FIFO empty; uop_valid=0, uop_tag=UOP_INT_ALU, uop_pc=0, uop_last=0,
//    uop_illegal=0, occupancy=0. dec_ready is 0 while rst high.
//  - dec_ready = !rst & !flush & (DEPTH - occupancy >= 2); independent of dec_valid/count.
//  - Group normalisation on accept:
//    matched & count==1 -> push {tag0,last=1}
//    matched & count==2 -> push {tag0,last=0} then {tag1,last=1}, same PC, same cycle
//    !matched or count==0 or count==3 -> push {UOP_INT_ALU,last=1,illegal=1}
//  - Pop when uop_valid & uop_ready; head advances 1 entry; uop_* driven from registered
//    head, stable while uop_valid & !uop_ready.
//  - Latency (no bypass): accepted group's first uop visible the next cycle.
//  - Push and pop same cycle: occupancy += pushed - 1; pointers wrap modulo DEPTH with an
//    extra wrap bit distinguishing full from empty.
//  - Full: dec_ready low at occupancy > DEPTH-2; no overflow possible.
//  - Empty: uop_valid=0; uop_ready ignored.
//  - flush: next cycle occupancy=0, uop_valid=0; a same-cycle group is not accepted
//    (dec_ready already 0); same-cycle pop has no effect beyond the clear.
//  - Reset mid-group (second uop pending): both entries discarded; no partial issue.
//  - Uops of one instruction are never split across a flush: flush drops them all.
// CONFIGURATION
//  DECODE_SEQ_BYPASS_EN defined: when FIFO empty, dec_valid, dec_ready and !flush, the
//    group's first uop is driven combinationally on uop_*; if uop_ready it is consumed
//    and only the remaining uop (if any) is written. Zero-cycle latency.
//  Undefined: no combinational path dec_* -> uop_*; one-cycle minimum latency.
// TESTING
//  1 reset: rst=1 2 cycles -> uop_valid=0, occupancy=0, dec_ready=0; rst low -> dec_ready=1
//  2 single: matched, tag0=UOP_LD_U8, count=1, pc=0x000100, uop_ready=1 -> next cycle
//    uop_tag=UOP_LD_U8, uop_pc=0x000100, uop_last=1, uop_illegal=0
//  3 pair: tag0=UOP_CAP_JUMP, tag1=UOP_LINK, count=2, pc=0x000204 -> CAP_JUMP last=0
//    then LINK last=1 on consecutive cycles, both pc=0x000204
//  4 backpressure: uop_ready=0, four count=1 groups (DEPTH=4) -> dec_ready low after 3rd
//    (occupancy 3); release -> 3 uops in order, no loss/duplication
//  5 illegal: matched=0, pc=0x000ABC -> one uop, UOP_INT_ALU, illegal=1, last=1
//  6 flush: occupancy 3, flush=1 with dec_valid=1 -> next cycle occupancy=0,
//    uop_valid=0, group not accepted; with BYPASS_EN, empty FIFO + uop_ready -> same cycle

Source files
------------

// File: rtl/decode_uop_sequencer.sv
// Decoded-group to micro-op sequencer: normalises each accepted group into 1-2 uops,
// queues them in a small FIFO and issues one per cycle. Optional macro DECODE_SEQ_BYPASS_EN
// adds a zero-latency path from dec_* to uop_* when the FIFO is empty.

package decode_uop_pkg;
  typedef enum logic [3:0] {
    UOP_INT_ALU  = 4'd0,
    UOP_INT_MUL  = 4'd1,
    UOP_LD_U8    = 4'd2,
    UOP_LD_W     = 4'd3,
    UOP_ST_W     = 4'd4,
    UOP_BRANCH   = 4'd5,
    UOP_CAP_JUMP = 4'd6,
    UOP_LINK     = 4'd7
  } uop_tag_t;
endpackage

module decode_uop_sequencer
  import decode_uop_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     dec_valid,
  output logic                     dec_ready,
  input  logic                     dec_matched,
  input  uop_tag_t                 dec_tag0,
  input  uop_tag_t                 dec_tag1,
  input  logic [1:0]               dec_count,
  input  logic [PC_W-1:0]          dec_pc,
  output logic                     uop_valid,
  input  logic                     uop_ready,
  output uop_tag_t                 uop_tag,
  output logic [PC_W-1:0]          uop_pc,
  output logic                     uop_last,
  output logic                     uop_illegal,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    uop_tag_t        tag;
    logic [PC_W-1:0] pc;
    logic            last;
    logic            illegal;
  } entry_t;

  localparam entry_t RST_ENTRY = '{UOP_INT_ALU, {PC_W{1'b0}}, 1'b0, 1'b0};

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

  logic [PW-1:0]   occ_s;
  logic [PW-1:0]   free_s;
  logic            empty_s;
  logic            accept_s;
  logic            grp_legal_s;
  logic            grp_pair_s;
  entry_t          e0_s, e1_s;
  entry_t          head_s;
  entry_t          out_s;
  entry_t          w0_s, w1_s;
  logic [1:0]      push_n_s;
  logic            byp_s;
  logic            pop_s;
  logic [AW-1:0]   wr_idx0_s, wr_idx1_s;

  assign occ_s     = wr_ptr_q - rd_ptr_q;
  assign free_s    = PW'(DEPTH) - occ_s;
  assign empty_s   = (occ_s == {PW{1'b0}});
  assign head_s    = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_idx0_s = wr_ptr_q[AW-1:0];
  assign wr_idx1_s = wr_ptr_q[AW-1:0] + AW'(1);

  assign dec_ready = !rst && !flush && (free_s >= PW'(2));
  assign accept_s  = dec_valid && dec_ready;

  // Turn the incoming group into its first and (optional) second uop.
  always_comb begin
    grp_legal_s = dec_matched && ((dec_count == 2'd1) || (dec_count == 2'd2));
    grp_pair_s  = grp_legal_s && (dec_count == 2'd2);
    e0_s.pc      = dec_pc;
    e0_s.illegal = !grp_legal_s;
    e0_s.last    = !grp_pair_s;
    if (grp_legal_s) begin
      e0_s.tag = dec_tag0;
    end else begin
      e0_s.tag = UOP_INT_ALU;
    end
    e1_s.tag     = dec_tag1;
    e1_s.pc      = dec_pc;
    e1_s.last    = 1'b1;
    e1_s.illegal = 1'b0;
  end

  // Output selection, pop decision and what gets written into the FIFO this cycle.
  always_comb begin
`ifdef DECODE_SEQ_BYPASS_EN
    byp_s = empty_s && accept_s;
`else
    byp_s = 1'b0;
`endif
    uop_valid = !empty_s || byp_s;
    pop_s     = !empty_s && uop_ready;
    if (byp_s) begin
      out_s = e0_s;
    end else if (!empty_s) begin
      out_s = head_s;
    end else begin
      out_s = RST_ENTRY;
    end

    push_n_s = 2'd0;
    w0_s     = e0_s;
    w1_s     = e1_s;
    if (!accept_s) begin
      push_n_s = 2'd0;
    end else if (byp_s && uop_ready) begin
      // First uop leaves straight through; only its partner (if any) is queued.
      push_n_s = grp_pair_s ? 2'd1 : 2'd0;
      w0_s     = e1_s;
    end else begin
      push_n_s = grp_pair_s ? 2'd2 : 2'd1;
    end
  end

  // FIFO storage and pointer next-state; flush clears both pointers.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
    end else begin
      if (push_n_s != 2'd0) begin
        mem_d[wr_idx0_s] = w0_s;
      end else begin
        mem_d[wr_idx0_s] = mem_q[wr_idx0_s];
      end
      if (push_n_s == 2'd2) begin
        mem_d[wr_idx1_s] = w1_s;
      end else begin
        mem_d[wr_idx1_s] = mem_q[wr_idx1_s];
      end
      wr_ptr_d = wr_ptr_q + PW'(push_n_s);
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_ENTRY;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign uop_tag     = out_s.tag;
  assign uop_pc      = out_s.pc;
  assign uop_last    = out_s.last;
  assign uop_illegal = out_s.illegal;
  assign occupancy   = occ_s;

endmodule

// File: tb/tb_decode_uop_sequencer.sv
// Self-checking bench for decode_uop_sequencer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model of the uop stream.

module tb_decode_uop_sequencer;
  import decode_uop_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 24;

  logic            clk = 1'b0;
  logic            rst, flush, dec_valid, dec_ready, dec_matched;
  uop_tag_t        dec_tag0, dec_tag1;
  logic [1:0]      dec_count;
  logic [PC_W-1:0] dec_pc;
  logic            uop_valid, uop_ready, uop_last, uop_illegal;
  uop_tag_t        uop_tag;
  logic [PC_W-1:0] uop_pc;
  logic [2:0]      occupancy;

  typedef struct {
    logic [3:0]      tag;
    logic [PC_W-1:0] pc;
    logic            last;
    logic            ill;
  } m_uop_t;

  m_uop_t model_q[$];
  int     checks = 0;
  int     errors = 0;

  decode_uop_sequencer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_matched(dec_matched),
    .dec_tag0(dec_tag0), .dec_tag1(dec_tag1), .dec_count(dec_count), .dec_pc(dec_pc),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_tag(uop_tag), .uop_pc(uop_pc),
    .uop_last(uop_last), .uop_illegal(uop_illegal), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the DUT outputs with the head of the model queue.
  task automatic check_outputs();
    check_val("occupancy", 32'(occupancy), 32'(model_q.size()));
    check_val("uop_valid", 32'(uop_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      check_val("uop_tag",     32'(uop_tag),     32'(model_q[0].tag));
      check_val("uop_pc",      32'(uop_pc),      32'(model_q[0].pc));
      check_val("uop_last",    32'(uop_last),    32'(model_q[0].last));
      check_val("uop_illegal", 32'(uop_illegal), 32'(model_q[0].ill));
    end
  endtask

  // One clock: drive at negedge, check ready, advance model, check outputs at next negedge.
  task automatic cycle(input logic v, input logic m, input uop_tag_t t0, input uop_tag_t t1,
                       input logic [1:0] cnt, input logic [PC_W-1:0] pc,
                       input logic rdy, input logic fl, input logic r);
    logic   exp_ready;
    m_uop_t u;
    rst = r; flush = fl; dec_valid = v; dec_matched = m;
    dec_tag0 = t0; dec_tag1 = t1; dec_count = cnt; dec_pc = pc; uop_ready = rdy;
    #1;
    exp_ready = !r && !fl && ((DEPTH - model_q.size()) >= 2);
    check_val("dec_ready", 32'(dec_ready), 32'(exp_ready));
    if (r || fl) begin
      model_q.delete();
    end else begin
      if (model_q.size() != 0 && rdy) void'(model_q.pop_front());
      if (v && exp_ready) begin
        if (m && (cnt == 2'd1 || cnt == 2'd2)) begin
          u = '{tag: t0, pc: pc, last: (cnt == 2'd1), ill: 1'b0};
          model_q.push_back(u);
          if (cnt == 2'd2) begin
            u = '{tag: t1, pc: pc, last: 1'b1, ill: 1'b0};
            model_q.push_back(u);
          end
        end else begin
          u = '{tag: 4'(UOP_INT_ALU), pc: pc, last: 1'b1, ill: 1'b1};
          model_q.push_back(u);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, UOP_INT_ALU, UOP_INT_ALU, 2'd0, '0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dec_valid = 1'b0; dec_matched = 1'b0;
    dec_tag0 = UOP_INT_ALU; dec_tag1 = UOP_INT_ALU; dec_count = 2'd0; dec_pc = '0;
    uop_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    cycle(1'b0, 1'b0, UOP_INT_ALU, UOP_INT_ALU, 2'd0, '0, 1'b0, 1'b0, 1'b1);
    check_val("rst_valid",   32'(uop_valid), 32'd0);
    check_val("rst_occ",     32'(occupancy), 32'd0);
    check_val("rst_ready",   32'(dec_ready), 32'd0);
    check_val("rst_tag",     32'(uop_tag),   32'(UOP_INT_ALU));
    check_val("rst_pc",      32'(uop_pc),    32'd0);
    check_val("rst_last",    32'(uop_last),  32'd0);
    check_val("rst_illegal", 32'(uop_illegal), 32'd0);
    rst = 1'b0;
    #1 check_val("post_rst_ready", 32'(dec_ready), 32'd1);

    // Single uop
    cycle(1'b1, 1'b1, UOP_LD_U8, UOP_INT_ALU, 2'd1, 24'h000100, 1'b1, 1'b0, 1'b0);
    check_val("single_tag",  32'(uop_tag),  32'(UOP_LD_U8));
    check_val("single_pc",   32'(uop_pc),   32'h000100);
    check_val("single_last", 32'(uop_last), 32'd1);
    check_val("single_ill",  32'(uop_illegal), 32'd0);

    // Pair CAP_JUMP + LINK
    cycle(1'b1, 1'b1, UOP_CAP_JUMP, UOP_LINK, 2'd2, 24'h000204, 1'b1, 1'b0, 1'b0);
    check_val("pair0_tag",  32'(uop_tag),  32'(UOP_CAP_JUMP));
    check_val("pair0_last", 32'(uop_last), 32'd0);
    check_val("pair0_pc",   32'(uop_pc),   32'h000204);
    idle(1'b1);
    check_val("pair1_tag",  32'(uop_tag),  32'(UOP_LINK));
    check_val("pair1_last", 32'(uop_last), 32'd1);
    check_val("pair1_pc",   32'(uop_pc),   32'h000204);
    idle(1'b1);
    check_val("pair_drained", 32'(uop_valid), 32'd0);

    // Backpressure: four singles with uop_ready low
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b1, UOP_LD_W, UOP_INT_ALU, 2'd1, 24'(24'h000300 + i * 4), 1'b0, 1'b0, 1'b0);
    check_val("bp_occ",   32'(occupancy), 32'd3);
    check_val("bp_ready", 32'(dec_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_val("bp_drain_pc", 32'(uop_pc), 32'(24'h000300 + i * 4));
      idle(1'b1);
    end
    check_val("bp_empty", 32'(uop_valid), 32'd0);

    // Illegal group
    cycle(1'b1, 1'b0, UOP_ST_W, UOP_LINK, 2'd2, 24'h000ABC, 1'b0, 1'b0, 1'b0);
    check_val("ill_tag",  32'(uop_tag),     32'(UOP_INT_ALU));
    check_val("ill_flag", 32'(uop_illegal), 32'd1);
    check_val("ill_last", 32'(uop_last),    32'd1);
    check_val("ill_occ",  32'(occupancy),   32'd1);
    idle(1'b1);

    // Flush with occupancy 3 and a group offered
    cycle(1'b1, 1'b1, UOP_CAP_JUMP, UOP_LINK, 2'd2, 24'h000400, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, UOP_BRANCH, UOP_INT_ALU, 2'd1, 24'h000408, 1'b0, 1'b0, 1'b0);
    check_val("fl_pre_occ", 32'(occupancy), 32'd3);
    cycle(1'b1, 1'b1, UOP_LD_U8, UOP_INT_ALU, 2'd1, 24'h00040C, 1'b1, 1'b1, 1'b0);
    check_val("fl_occ",   32'(occupancy), 32'd0);
    check_val("fl_valid", 32'(uop_valid), 32'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0,
            $urandom_range(0, 7) != 0,
            uop_tag_t'(4'($urandom_range(0, 7))),
            uop_tag_t'(4'($urandom_range(0, 7))),
            2'($urandom_range(0, 3)),
            24'($urandom),
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 63) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
